// File: rtl/bram_pkg.sv
// bram_pkg: shared types and helpers for the dual-port block RAM.
//   bram_state_t : init sequencer states
//   BYTE_W       : byte-lane width used for byte enables
//   byte_merge   : per-lane write merge (new byte when enabled, else old byte)
package bram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bram_state_t;

  function automatic logic [BYTE_W-1:0] byte_merge(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/bram_init_fsm.sv
// bram_init_fsm: walks every word address once after reset or clear so the
// top can overwrite the memory with its init value, then reports ready.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (priority over clear)
//   clear     in   1-cycle pulse, restarts the init walk from address 0
//   ready     out  1 while in ST_RUN
//   init_we   out  1 while in ST_INIT, init write strobe
//   init_addr out  address being initialised this cycle
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | writing init value at init_addr, one word per cycle
// ST_RUN  | memory initialised, ports served
module bram_init_fsm
  import bram_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  bram_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_addr;

  assign last_addr = &addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ready     = 1'b0;
    init_we   = 1'b0;
    init_addr = addr_q;
    unique case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (clear) begin
          addr_d = '0;
        end else if (last_addr) begin
          state_d = ST_RUN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        if (clear) begin
          state_d = ST_INIT;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        addr_d  = '0;
      end
    endcase
  end

endmodule

// File: rtl/bram_dp.sv
// bram_dp: dual-port block RAM. Port A read/write with byte enables,
// port B read-only. Contents are filled with INIT_VALUE by a hardware
// sequencer after reset or a clear pulse; requests are ignored until ready.
// Reads are read-first on both ports.
// Build option: define BRAM_DP_OUT_REG_EN to add an output register on both
// ports (read latency 2 instead of 1, rvalid pipelined with the data).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   clear                    1-cycle pulse, re-run init
//   ready                    1 = init done, requests accepted
//   a_addr/a_chipselect_n/a_write_n/a_read_n/a_byte_en/a_data_in  port A request
//   a_data_out/a_rvalid      port A read data and 1-cycle valid
//   b_addr/b_chipselect_n/b_read_n                                port B request
//   b_data_out/b_rvalid      port B read data and 1-cycle valid
module bram_dp
  import bram_pkg::*;
#(
  parameter int                         BRAM_ADDR_WIDTH = 15,
  parameter int                         BRAM_DATA_WIDTH = 16,
  parameter logic [BRAM_DATA_WIDTH-1:0] INIT_VALUE      = '0,
  localparam int                        NUM_BYTES       = BRAM_DATA_WIDTH / BYTE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  output logic                       ready,
  input  logic [BRAM_ADDR_WIDTH-1:0] a_addr,
  input  logic                       a_chipselect_n,
  input  logic                       a_write_n,
  input  logic                       a_read_n,
  input  logic [NUM_BYTES-1:0]       a_byte_en,
  input  logic [BRAM_DATA_WIDTH-1:0] a_data_in,
  output logic [BRAM_DATA_WIDTH-1:0] a_data_out,
  output logic                       a_rvalid,
  input  logic [BRAM_ADDR_WIDTH-1:0] b_addr,
  input  logic                       b_chipselect_n,
  input  logic                       b_read_n,
  output logic [BRAM_DATA_WIDTH-1:0] b_data_out,
  output logic                       b_rvalid
);

  localparam int DEPTH = 1 << BRAM_ADDR_WIDTH;

  logic [BRAM_DATA_WIDTH-1:0] mem [DEPTH];

  logic                       init_we;
  logic [BRAM_ADDR_WIDTH-1:0] init_addr;

  logic a_wr, a_rd, b_rd;

  logic                       wr_en;
  logic [BRAM_ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_BYTES-1:0]       wr_be;
  logic [BRAM_DATA_WIDTH-1:0] wr_data;

  logic [BRAM_DATA_WIDTH-1:0] a_rd_data_q, b_rd_data_q;
  logic                       a_rv_q, b_rv_q;

  bram_init_fsm #(
    .ADDR_W (BRAM_ADDR_WIDTH)
  ) u_init_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  assign a_wr = ready & ~a_chipselect_n & ~a_write_n;
  assign a_rd = ready & ~a_chipselect_n & ~a_read_n;
  assign b_rd = ready & ~b_chipselect_n & ~b_read_n;

  // The init sequencer borrows port A's write path; a_wr is already 0 then
  // because ready is low, so the override never drops a real request.
  always_comb begin
    wr_en   = a_wr;
    wr_addr = a_addr;
    wr_be   = a_byte_en;
    wr_data = a_data_in;
    if (init_we) begin
      wr_en   = 1'b1;
      wr_addr = init_addr;
      wr_be   = '1;
      wr_data = INIT_VALUE;
    end
  end

  // Memory array has no reset; the init sequencer fills it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        mem[wr_addr][i*BYTE_W +: BYTE_W] <=
          byte_merge(mem[wr_addr][i*BYTE_W +: BYTE_W], wr_data[i*BYTE_W +: BYTE_W], wr_be[i]);
      end
    end
  end

  // Non-blocking reads of the array give read-first behaviour against the
  // write above, for same-port and cross-port collisions alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd_data_q <= '0;
      a_rv_q      <= 1'b0;
      b_rd_data_q <= '0;
      b_rv_q      <= 1'b0;
    end else begin
      a_rv_q <= a_rd;
      b_rv_q <= b_rd;
      if (a_rd) a_rd_data_q <= mem[a_addr];
      if (b_rd) b_rd_data_q <= mem[b_addr];
    end
  end

`ifdef BRAM_DP_OUT_REG_EN
  logic [BRAM_DATA_WIDTH-1:0] a_out_q, b_out_q;
  logic                       a_rv2_q, b_rv2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_q <= '0;
      a_rv2_q <= 1'b0;
      b_out_q <= '0;
      b_rv2_q <= 1'b0;
    end else begin
      a_rv2_q <= a_rv_q;
      b_rv2_q <= b_rv_q;
      if (a_rv_q) a_out_q <= a_rd_data_q;
      if (b_rv_q) b_out_q <= b_rd_data_q;
    end
  end

  assign a_data_out = a_out_q;
  assign a_rvalid   = a_rv2_q;
  assign b_data_out = b_out_q;
  assign b_rvalid   = b_rv2_q;
`else
  assign a_data_out = a_rd_data_q;
  assign a_rvalid   = a_rv_q;
  assign b_data_out = b_rd_data_q;
  assign b_rvalid   = b_rv_q;
`endif

endmodule

// File: tb/tb_bram_dp.sv
`timescale 1ns/1ps
module tb_bram_dp;

  localparam int          AW = 4;
  localparam int          DW = 16;
  localparam logic [15:0] IV = 16'hA5A5;
`ifdef BRAM_DP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk, rst, clear, ready;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_chipselect_n, a_write_n, a_read_n, a_rvalid;
  logic [1:0]    a_byte_en;
  logic [DW-1:0] a_data_in, a_data_out, b_data_out;
  logic          b_chipselect_n, b_read_n, b_rvalid;

  bram_dp #(
    .BRAM_ADDR_WIDTH (AW),
    .BRAM_DATA_WIDTH (DW),
    .INIT_VALUE      (IV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .ready          (ready),
    .a_addr         (a_addr),
    .a_chipselect_n (a_chipselect_n),
    .a_write_n      (a_write_n),
    .a_read_n       (a_read_n),
    .a_byte_en      (a_byte_en),
    .a_data_in      (a_data_in),
    .a_data_out     (a_data_out),
    .a_rvalid       (a_rvalid),
    .b_addr         (b_addr),
    .b_chipselect_n (b_chipselect_n),
    .b_read_n       (b_read_n),
    .b_data_out     (b_data_out),
    .b_rvalid       (b_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          a_wr;
    logic          a_cs_n;
    logic [AW-1:0] a_addr;
    logic [1:0]    a_be;
    logic [DW-1:0] a_wdata;
    logic          b_rd;
    logic          b_cs_n;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_exp;
  } vec_t;

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] last_b  = '0;
  vec_t          vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    check(name, {16'b0, act}, {16'b0, exp});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    clear          = 1'b0;
    a_chipselect_n = 1'b1;
    a_write_n      = 1'b1;
    a_read_n       = 1'b1;
    a_byte_en      = 2'b00;
    a_data_in      = '0;
    b_chipselect_n = 1'b1;
    b_read_n       = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 64) begin
      n++;
      step();
    end
  endtask

  // Apply one vector for a single cycle, then check port B after LAT cycles.
  task automatic run_vec(input vec_t v, input string tag);
    logic exp_rv;
    a_chipselect_n = v.a_cs_n;
    a_write_n      = ~v.a_wr;
    a_read_n       = 1'b1;
    a_addr         = v.a_addr;
    a_byte_en      = v.a_be;
    a_data_in      = v.a_wdata;
    b_chipselect_n = v.b_cs_n;
    b_read_n       = ~v.b_rd;
    b_addr         = v.b_addr;
    step();
    idle();
`ifdef BRAM_DP_OUT_REG_EN
    check_bit({tag, "_rv_early"}, b_rvalid, 1'b0);
    step();
`endif
    exp_rv = v.b_rd & ~v.b_cs_n;
    check_bit({tag, "_rv"}, b_rvalid, exp_rv);
    if (exp_rv) begin
      check_word({tag, "_data"}, b_data_out, v.b_exp);
      last_b = v.b_exp;
    end else begin
      check_word({tag, "_hold"}, b_data_out, last_b);
    end
  endtask

  task automatic a_access(input logic wr, input logic [AW-1:0] addr, input logic [1:0] be,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp, input string tag);
    a_chipselect_n = 1'b0;
    a_write_n      = ~wr;
    a_read_n       = 1'b0;
    a_addr         = addr;
    a_byte_en      = be;
    a_data_in      = wd;
    step();
    idle();
`ifdef BRAM_DP_OUT_REG_EN
    check_bit({tag, "_rv_early"}, a_rvalid, 1'b0);
    step();
`endif
    check_bit({tag, "_rv"}, a_rvalid, 1'b1);
    check_word({tag, "_data"}, a_data_out, exp);
  endtask

  initial begin
    int   n;
    vec_t v;

    //       a_wr  a_cs  addr  be     wdata     b_rd  b_cs  addr  b_exp
    vecs[0]  = '{1'b1, 1'b0, 4'd3,  2'b11, 16'h1234, 1'b0, 1'b1, 4'd0,  16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 4'd3,  2'b01, 16'h00FF, 1'b0, 1'b1, 4'd0,  16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 4'd0,  2'b00, 16'h0000, 1'b1, 1'b0, 4'd3,  16'h12FF};
    vecs[3]  = '{1'b1, 1'b0, 4'd5,  2'b11, 16'hBEEF, 1'b1, 1'b0, 4'd5,  16'hA5A5};
    vecs[4]  = '{1'b0, 1'b1, 4'd0,  2'b00, 16'h0000, 1'b1, 1'b0, 4'd5,  16'hBEEF};
    vecs[5]  = '{1'b1, 1'b0, 4'd9,  2'b00, 16'hFFFF, 1'b0, 1'b1, 4'd0,  16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 4'd0,  2'b00, 16'h0000, 1'b1, 1'b0, 4'd9,  16'hA5A5};
    vecs[7]  = '{1'b1, 1'b0, 4'd0,  2'b10, 16'h7700, 1'b0, 1'b1, 4'd0,  16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 4'd0,  2'b00, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h77A5};
    vecs[9]  = '{1'b1, 1'b0, 4'd15, 2'b11, 16'h0F0F, 1'b0, 1'b1, 4'd0,  16'h0000};
    vecs[10] = '{1'b0, 1'b1, 4'd0,  2'b00, 16'h0000, 1'b1, 1'b0, 4'd15, 16'h0F0F};
    vecs[11] = '{1'b1, 1'b1, 4'd2,  2'b11, 16'h9999, 1'b1, 1'b1, 4'd2,  16'h0000};
    vecs[12] = '{1'b0, 1'b1, 4'd0,  2'b00, 16'h0000, 1'b1, 1'b0, 4'd2,  16'hA5A5};
    vecs[13] = '{1'b1, 1'b0, 4'd3,  2'b10, 16'hAB00, 1'b1, 1'b0, 4'd3,  16'h12FF};
    vecs[14] = '{1'b0, 1'b1, 4'd0,  2'b00, 16'h0000, 1'b1, 1'b0, 4'd3,  16'hABFF};

    idle();
    a_addr = '0;
    b_addr = '0;
    rst    = 1'b1;
    step();
    step();
    check_bit("rst_ready", ready, 1'b0);
    check_bit("rst_a_rvalid", a_rvalid, 1'b0);
    check_bit("rst_b_rvalid", b_rvalid, 1'b0);
    check_word("rst_a_data", a_data_out, 16'h0000);
    check_word("rst_b_data", b_data_out, 16'h0000);
    rst = 1'b0;
    wait_ready(n);
    check("rst_ready_cycles", n, 16);
    check_bit("rst_ready_up", ready, 1'b1);

    for (int i = 0; i < 16; i++) begin
      v = '{1'b0, 1'b1, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b0, 4'(i), IV};
      run_vec(v, $sformatf("init_rd%0d", i));
    end

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Port A read-first on a same-cycle read+write, then read-back and hold.
    a_access(1'b1, 4'd3, 2'b11, 16'h5555, 16'hABFF, "a_rw");
    step();
    check_bit("a_idle_rv", a_rvalid, 1'b0);
    check_word("a_idle_hold", a_data_out, 16'hABFF);
    a_access(1'b0, 4'd3, 2'b00, 16'h0000, 16'h5555, "a_rd");

    // Clear: the read issued alongside clear still completes; requests
    // during init are ignored and memory comes back to IV.
    v = '{1'b1, 1'b0, 4'd7, 2'b11, 16'h0001, 1'b0, 1'b1, 4'd0, 16'h0000};
    run_vec(v, "clr_wr");
    clear          = 1'b1;
    b_chipselect_n = 1'b0;
    b_read_n       = 1'b0;
    b_addr         = 4'd7;
    step();
    idle();
    n = 0;
    while (!ready && n < 64) begin
      check_bit($sformatf("clr_b_rv%0d", n), b_rvalid, (n == LAT - 1));
      if (n == LAT - 1) check_word("clr_b_data", b_data_out, 16'h0001);
      check_bit($sformatf("clr_a_rv%0d", n), a_rvalid, 1'b0);
      a_chipselect_n = 1'b0;
      a_write_n      = 1'b0;
      a_read_n       = 1'b0;
      a_addr         = 4'd7;
      a_byte_en      = 2'b11;
      a_data_in      = 16'h1111;
      b_chipselect_n = 1'b0;
      b_read_n       = 1'b0;
      b_addr         = 4'd7;
      n++;
      step();
    end
    idle();
    check("clr_ready_cycles", n, 16);
    check_bit("clr_after_rv", b_rvalid, 1'b0);
    check_word("clr_after_hold", b_data_out, 16'h0001);
    last_b = 16'h0001;
    v = '{1'b0, 1'b1, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b0, 4'd7, IV};
    run_vec(v, "clr_rd7");

    // Reset in the middle of an init walk restarts it from address 0.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_bit("mid_ready_low", ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_word("mid_rst_b_data", b_data_out, 16'h0000);
    check_bit("mid_rst_b_rv", b_rvalid, 1'b0);
    wait_ready(n);
    check("mid_ready_cycles", n, 16);
    last_b = 16'h0000;
    v = '{1'b0, 1'b1, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b0, 4'd15, IV};
    run_vec(v, "mid_rd15");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
